// File: rtl/rom_burst_reader.sv
// Parametrised constant ROM (word[a] = a+1) with a burst-read sequencer and valid/ready output.
// Optional `ROM_PARITY_EN adds a registered even-parity bit (rd_parity) alongside rd_data.
module rom_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
`ifdef ROM_PARITY_EN
    ,
    output logic                  rd_parity
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [LEN_WIDTH-1:0]    rem;
    logic [DATA_WIDTH-1:0]   rom [DEPTH];

    // Contents fixed by the parameters; the cast truncates, giving the modulo wrap.
    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = DATA_WIDTH'(a + 1);
    end

    assign addr_nxt = addr + ADDR_WIDTH'(1);
    assign rd_last  = rd_valid && (rem == LEN_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ROM_PARITY_EN
            rd_parity <= 1'b0;
`endif
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            addr  <= base_addr;
                            rem   <= burst_len;
                            busy  <= 1'b1;
                            state <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    rd_data  <= rom[addr];
`ifdef ROM_PARITY_EN
                    rd_parity <= ^rom[addr];
`endif
                    rd_valid <= 1'b1;
                    state    <= STREAM;
                end
                STREAM: begin
                    // Without an accepted beat everything holds, so data stays stable under stall.
                    if (rd_valid && rd_ready) begin
                        if (rem > LEN_WIDTH'(1)) begin
                            addr    <= addr_nxt;
                            rd_data <= rom[addr_nxt];
`ifdef ROM_PARITY_EN
                            rd_parity <= ^rom[addr_nxt];
`endif
                            rem     <= rem - LEN_WIDTH'(1);
                        end else begin
                            rem      <= '0;
                            rd_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
